// File: rtl/timer_pkg.sv
// Shared types for the interval timing blocks.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } meter_state_e;

endpackage

// File: rtl/sat_upcounter.sv
// Up-counter that loads to 1 and saturates at MAX.
// sat stays set until the next load once an increment is refused at MAX.
module sat_upcounter #(
  parameter int MAX = 100,
  localparam int W  = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  localparam logic [W-1:0] MAX_Q = W'(MAX);

  logic [W-1:0] q_q, q_d;
  logic         sat_q, sat_d;

  always_comb begin
    q_d   = q_q;
    sat_d = sat_q;
    if (load) begin
      q_d   = W'(1);
      sat_d = 1'b0;
    end else if (inc) begin
      if (q_q == MAX_Q) begin
        sat_d = 1'b1;
      end else begin
        q_d = q_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      sat_q <= sat_d;
    end
  end

  assign q   = q_q;
  assign sat = sat_q;

endmodule

// File: rtl/interval_meter.sv
// Measures start-to-stop interval in clk cycles, holds the result until ack,
// and tracks min/max of captured intervals.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | measuring, counter advancing
// HOLD  | result held on count/overflow, waiting for ack
module interval_meter
  import timer_pkg::*;
#(
  parameter int MAX_COUNT = 100,
  localparam int W        = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         ack,
  input  logic         stats_clr,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] count,
  output logic         overflow,
  output logic [W-1:0] min_count,
  output logic [W-1:0] max_count
);

  localparam logic [W-1:0] MAX_Q = W'(MAX_COUNT);

  meter_state_e state_q, state_d;
  logic         cnt_load, cnt_inc, capture;
  logic [W-1:0] cnt;
  logic         ovf;

  logic [W-1:0] count_q, count_d;
  logic         overflow_q, overflow_d;
  logic [W-1:0] min_q, min_d;
  logic [W-1:0] max_q, max_d;

  sat_upcounter #(.MAX(MAX_COUNT)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .inc  (cnt_inc),
    .q    (cnt),
    .sat  (ovf)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        // stop beats a coincident start
        if (stop) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (start) begin
          cnt_load = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      HOLD: begin
        if (ack) begin
          if (start) begin
            cnt_load = 1'b1;
            state_d  = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    min_d      = min_q;
    max_d      = max_q;
    if (capture) begin
      count_d    = cnt;
      overflow_d = ovf;
      // a capture alongside stats_clr restarts the statistics at this value
      min_d      = (stats_clr || cnt < min_q) ? cnt : min_q;
      max_d      = (stats_clr || cnt > max_q) ? cnt : max_q;
    end else if (stats_clr) begin
      min_d = MAX_Q;
      max_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      min_q      <= MAX_Q;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      min_q      <= min_d;
      max_q      <= max_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign valid     = (state_q == HOLD);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign min_count = min_q;
  assign max_count = max_q;

endmodule

// File: tb/tb_interval_meter.sv
// Directed bench for interval_meter with MAX_COUNT=100.
module tb_interval_meter;

  localparam int MAXC = 100;
  localparam int W    = $clog2(MAXC + 1);

  logic         clk = 1'b0;
  logic         rst, start, stop, ack, stats_clr;
  logic         busy, valid, overflow;
  logic [W-1:0] count, min_count, max_count;

  int tests_run    = 0;
  int tests_failed = 0;

  interval_meter #(.MAX_COUNT(MAXC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .ack       (ack),
    .stats_clr (stats_clr),
    .busy      (busy),
    .valid     (valid),
    .count     (count),
    .overflow  (overflow),
    .min_count (min_count),
    .max_count (max_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(1); ack = 1'b0;
  endtask

  // start, n-1 quiet cycles, stop -> interval n; then acknowledge
  task automatic measure(input int n);
    pulse_start();
    step(n - 1);
    pulse_stop();
    pulse_ack();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0; stats_clr = 1'b0;
    step(3);
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || valid !== 1'b0 || count !== 0 || overflow !== 1'b0 ||
        min_count !== 7'(MAXC) || max_count !== 0) begin
      tests_failed++;
      $display("FAIL reset: busy=%0b valid=%0b count=%0d ovf=%0b min=%0d max=%0d, want 0 0 0 0 100 0",
               busy, valid, count, overflow, min_count, max_count);
    end
  endtask

  task automatic test_basic();
    pulse_start();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL basic_busy: got %0b want 1", busy);
    end
    step(6);
    pulse_stop();
    tests_run++;
    if (valid !== 1'b1 || busy !== 1'b0 || count !== 7 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: valid=%0b busy=%0b count=%0d ovf=%0b, want 1 0 7 0",
               valid, busy, count, overflow);
    end
    tests_run++;
    if (min_count !== 7 || max_count !== 7) begin
      tests_failed++;
      $display("FAIL basic_stats: min=%0d max=%0d, want 7 7", min_count, max_count);
    end
    step(6);
    tests_run++;
    if (valid !== 1'b1 || count !== 7) begin
      tests_failed++;
      $display("FAIL basic_hold: valid=%0b count=%0d, want 1 7", valid, count);
    end
    pulse_ack();
    tests_run++;
    if (valid !== 1'b0 || busy !== 1'b0 || count !== 7) begin
      tests_failed++;
      $display("FAIL basic_ack: valid=%0b busy=%0b count=%0d, want 0 0 7", valid, busy, count);
    end
  endtask

  task automatic test_overflow();
    int busy_drops = 0;
    pulse_start();
    for (int i = 0; i < 150; i++) begin
      if (busy !== 1'b1) busy_drops++;
      step(1);
    end
    tests_run++;
    if (busy_drops != 0) begin
      tests_failed++;
      $display("FAIL ovf_busy: busy low in %0d cycles, want 0", busy_drops);
    end
    pulse_stop();
    tests_run++;
    if (valid !== 1'b1 || count !== 7'(MAXC) || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_result: valid=%0b count=%0d ovf=%0b, want 1 100 1", valid, count, overflow);
    end
    tests_run++;
    if (min_count !== 7 || max_count !== 7'(MAXC)) begin
      tests_failed++;
      $display("FAIL ovf_stats: min=%0d max=%0d, want 7 100", min_count, max_count);
    end
    pulse_ack();
  endtask

  task automatic test_restart();
    pulse_start();
    step(4);
    pulse_start();
    step(2);
    pulse_stop();
    tests_run++;
    if (valid !== 1'b1 || count !== 3 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart: valid=%0b count=%0d ovf=%0b, want 1 3 0", valid, count, overflow);
    end
    pulse_ack();
    pulse_start();
    step(3);
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    tests_run++;
    if (valid !== 1'b1 || busy !== 1'b0 || count !== 4) begin
      tests_failed++;
      $display("FAIL start_stop_same: valid=%0b busy=%0b count=%0d, want 1 0 4", valid, busy, count);
    end
    pulse_ack();
    pulse_ack();
    tests_run++;
    if (valid !== 1'b0 || busy !== 1'b0 || count !== 4) begin
      tests_failed++;
      $display("FAIL idle_ack: valid=%0b busy=%0b count=%0d, want 0 0 4", valid, busy, count);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    step(1);
    pulse_stop();
    pulse_start();
    pulse_stop();
    tests_run++;
    if (valid !== 1'b1 || busy !== 1'b0 || count !== 2) begin
      tests_failed++;
      $display("FAIL hold_ignore: valid=%0b busy=%0b count=%0d, want 1 0 2", valid, busy, count);
    end
    ack = 1'b1; start = 1'b1; step(1); ack = 1'b0; start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_start: busy=%0b valid=%0b, want 1 0", busy, valid);
    end
    step(3);
    pulse_stop();
    tests_run++;
    if (valid !== 1'b1 || count !== 4) begin
      tests_failed++;
      $display("FAIL back_to_back: valid=%0b count=%0d, want 1 4", valid, count);
    end
    pulse_ack();
  endtask

  task automatic test_stats();
    stats_clr = 1'b1; step(1); stats_clr = 1'b0;
    measure(7);
    measure(3);
    measure(12);
    tests_run++;
    if (min_count !== 3 || max_count !== 12) begin
      tests_failed++;
      $display("FAIL stats_track: min=%0d max=%0d, want 3 12", min_count, max_count);
    end
    stats_clr = 1'b1; step(1); stats_clr = 1'b0;
    tests_run++;
    if (min_count !== 7'(MAXC) || max_count !== 0) begin
      tests_failed++;
      $display("FAIL stats_clr: min=%0d max=%0d, want 100 0", min_count, max_count);
    end
    pulse_start();
    step(4);
    stop = 1'b1; stats_clr = 1'b1; step(1); stop = 1'b0; stats_clr = 1'b0;
    tests_run++;
    if (count !== 5 || min_count !== 5 || max_count !== 5) begin
      tests_failed++;
      $display("FAIL clr_capture: count=%0d min=%0d max=%0d, want 5 5 5", count, min_count, max_count);
    end
    pulse_ack();
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    step(39);
    rst = 1'b1; step(1); rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || valid !== 1'b0 || count !== 0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_run: busy=%0b valid=%0b count=%0d ovf=%0b, want 0 0 0 0",
               busy, valid, count, overflow);
    end
    pulse_stop();
    step(1);
    tests_run++;
    if (busy !== 1'b0 || valid !== 1'b0 || count !== 0) begin
      tests_failed++;
      $display("FAIL rst_stop: busy=%0b valid=%0b count=%0d, want 0 0 0", busy, valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_restart();
    test_back_to_back();
    test_stats();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/interval_meter.md
INTERVAL_METER -- requirements
Module: interval_meter

Interface
REQ-001 Parameter: MAX_COUNT, default 100, largest reportable interval in clock cycles; must be >= 2.
REQ-002 Local width W = $clog2(MAX_COUNT+1).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle pulse; begins a measurement.
REQ-006 stop  input  1  single-cycle pulse; ends a measurement.
REQ-007 ack  input  1  consumer acknowledges the held result.
REQ-008 stats_clr  input  1  clears min/max statistics.
REQ-009 busy  output  1  high while measuring (state RUN).
REQ-010 valid  output  1  high while a result is held (state HOLD).
REQ-011 count  output  W  captured interval in cycles.
REQ-012 overflow  output  1  captured interval saturated at MAX_COUNT.
REQ-013 min_count  output  W  smallest captured count since reset/clear.
REQ-014 max_count  output  W  largest captured count since reset/clear.

Function
REQ-015 FSM states IDLE, RUN, HOLD; all outputs registered, no combinational input-to-output paths.
REQ-016 IDLE: start -> RUN; internal counter cnt loaded with 1; stop ignored, including when coincident with start.
REQ-017 RUN: each cycle without stop: cnt increments, saturating at MAX_COUNT; the saturating increment sets an internal ovf flag.
REQ-018 Interval definition: start sampled at edge t, stop sampled at edge t+n -> count = min(n, MAX_COUNT); minimum reportable count is 1.
REQ-019 RUN + stop: count <= cnt, overflow <= ovf, update min/max, -> HOLD; valid rises on the next cycle (1-cycle latency).
REQ-020 RUN + start without stop: restart; cnt <= 1, ovf <= 0, state remains RUN.
REQ-021 RUN + start + stop in the same cycle: stop wins; result is captured and start is dropped.
REQ-022 HOLD: count/overflow stable until ack; ack -> IDLE; start without ack is ignored; stop is ignored.
REQ-023 HOLD + ack + start in the same cycle: -> RUN directly with cnt <= 1 (back-to-back measurement).
REQ-024 ack outside HOLD has no effect; count/overflow retain their last values in IDLE and RUN.
REQ-025 min/max update on every capture, including saturated captures: min_count <= min(min_count, cnt), max_count <= max(max_count, cnt).
REQ-026 stats_clr: min_count <= MAX_COUNT, max_count <= 0; a capture in the same cycle wins, so min_count = max_count = the captured value.

Reset
REQ-027 rst has priority over all inputs in every state; -> IDLE next cycle.
REQ-028 Reset values: busy=0, valid=0, count=0, overflow=0, cnt=0, ovf=0, max_count=0, min_count=MAX_COUNT.
REQ-029 Reset during RUN or HOLD abandons the measurement; no result is reported.

Structure
REQ-030 Shared package timer_pkg holds the state enum typedef (IDLE, RUN, HOLD).
REQ-031 The saturating counter is sub-module sat_upcounter (parameter MAX; inputs load, inc; outputs q, sat).
REQ-032 The min/max tracker stays inline in interval_meter.

Verification (MAX_COUNT=100)
REQ-033 start at cycle 10, stop at cycle 17 -> valid=1 from cycle 18, count=7, overflow=0, min=max=7; ack at cycle 25 -> valid=0 at cycle 26.
REQ-034 start, then 150 cycles without stop, then stop -> count=100, overflow=1, busy=1 throughout the run.
REQ-035 start at cycle 0, start at cycle 5, stop at cycle 8 -> count=3; separately, start and stop together in RUN -> result captured.
REQ-036 In HOLD: start alone -> ignored, valid stays 1; ack+start together -> busy=1 next cycle; stop 4 cycles later -> count=4.
REQ-037 Intervals 7, 3, 12 -> min=3, max=12; stats_clr -> min=100, max=0; stats_clr coincident with a capture of 5 -> min=max=5.
REQ-038 rst asserted mid-RUN at cnt=40 -> next cycle busy=0, valid=0, count=0; a following stop is ignored.
